// File: rtl/hssl_vio_ctl_pkg.sv
// Shared types and widths for the HSSL VIO control block.
package hssl_vio_ctl_pkg;

   localparam int PULSE_W = 16;
   localparam int TMO_W   = 24;
   localparam int SEQ_W   = 16;

   localparam int KIND_ALL   = 0;
   localparam int KIND_TX    = 1;
   localparam int KIND_RX    = 2;
   localparam int KIND_RX_DP = 3;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_PULSE = 2'd1,
      ST_WAIT  = 2'd2
   } state_t;

   typedef enum logic [1:0] {
      K_ALL   = 2'd0,
      K_TX    = 2'd1,
      K_RX    = 2'd2,
      K_RX_DP = 2'd3
   } kind_t;

   function automatic logic [3:0] kind_onehot(input kind_t k);
      logic [3:0] v;
      v = '0;
      v[k] = 1'b1;
      return v;
   endfunction

   // bit 0 = tx reset-done, bit 1 = rx reset-done
   function automatic logic [1:0] kind_done_req(input kind_t k);
      logic [1:0] v;
      case (k)
         K_ALL:   v = 2'b11;
         K_TX:    v = 2'b01;
         default: v = 2'b10;
      endcase
      return v;
   endfunction

endpackage

// File: rtl/hssl_vio_ctl_if.sv
// VIO request/status and GTH reset-helper signals; master = controller side.
interface hssl_vio_ctl_if;
   import hssl_vio_ctl_pkg::*;

   logic             vio_reset_all;
   logic             vio_reset_tx;
   logic             vio_reset_rx;
   logic             vio_reset_rx_dp;
   logic [2:0]       vio_loopback;
   logic             gt_tx_reset_done;
   logic             gt_rx_reset_done;
   logic             gt_reset_all;
   logic             gt_reset_tx;
   logic             gt_reset_rx;
   logic             gt_reset_rx_dp;
   logic [2:0]       gt_loopback;
   logic             busy;
   logic             timeout;
   logic [SEQ_W-1:0] seq_count;
   logic             tx_done_sync;
   logic             rx_done_sync;

   modport master (
      input  vio_reset_all, vio_reset_tx, vio_reset_rx, vio_reset_rx_dp, vio_loopback,
      input  gt_tx_reset_done, gt_rx_reset_done,
      output gt_reset_all, gt_reset_tx, gt_reset_rx, gt_reset_rx_dp, gt_loopback,
      output busy, timeout, seq_count, tx_done_sync, rx_done_sync
   );

   modport slave (
      output vio_reset_all, vio_reset_tx, vio_reset_rx, vio_reset_rx_dp, vio_loopback,
      output gt_tx_reset_done, gt_rx_reset_done,
      input  gt_reset_all, gt_reset_tx, gt_reset_rx, gt_reset_rx_dp, gt_loopback,
      input  busy, timeout, seq_count, tx_done_sync, rx_done_sync
   );

endinterface

// File: rtl/hssl_bit_sync.sv
// Single-bit multi-flop synchroniser into clk; output is d delayed by STAGES cycles.
module hssl_bit_sync #(
   parameter int STAGES = 2
) (
   input  logic clk,
   input  logic reset,
   input  logic d,
   output logic q
);

   (* ASYNC_REG = "TRUE" *) logic [STAGES-1:0] sr;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) sr <= '0;
      else       sr <= {sr[STAGES-2:0], d};
   end

   assign q = sr[STAGES-1];

endmodule

// File: rtl/hssl_vio_ctl.sv
// Sequences GTH reset pulses and loopback changes from VIO request edges; request-to-pulse SYNC_STAGES+2 cycles.
// HSSL_VIO_CTL_AUTO_RETRY_EN adds up to MAX_RETRY re-pulses after a reset-done timeout.
module hssl_vio_ctl
   import hssl_vio_ctl_pkg::*;
#(
   parameter int SYNC_STAGES = 2,
   parameter int PULSE_CYC   = 16,
`ifdef HSSL_VIO_CTL_AUTO_RETRY_EN
   parameter int MAX_RETRY   = 3,
`endif
   parameter int TIMEOUT_CYC = 1048576
) (
   input  logic           clk,
   input  logic           reset,
   hssl_vio_ctl_if.master io
);

   logic [8:0]         async_in;
   logic [8:0]         sync_out;
   logic [3:0]         req_sync;
   logic [2:0]         lb_sync;
   logic [1:0]         done_sync;
   logic [3:0]         req_prev;
   logic [3:0]         req_edge;

   state_t             state, state_nxt;
   kind_t              kind, kind_nxt;
   logic [3:0]         pending, pend_nxt, pend_clr;
   logic [PULSE_W-1:0] pulse_cnt, pulse_cnt_nxt;
   logic [TMO_W-1:0]   tmo_cnt, tmo_cnt_nxt;
   logic [1:0]         seen_low, seen_low_nxt;
   logic [1:0]         need;
   logic [2:0]         loopback_q, loopback_nxt;
   logic [3:0]         gt_rst, gt_rst_nxt;
   logic               busy_q, busy_nxt;
   logic               timeout_q, timeout_nxt;
   logic [SEQ_W-1:0]   seq_cnt, seq_nxt;
   logic               pulse_entry;
   logic               new_seq;

`ifdef HSSL_VIO_CTL_AUTO_RETRY_EN
   localparam int RETRY_W = 8;
   logic [RETRY_W-1:0] retry_cnt, retry_nxt;
`endif

   assign async_in = {io.gt_rx_reset_done, io.gt_tx_reset_done, io.vio_loopback,
                      io.vio_reset_rx_dp, io.vio_reset_rx, io.vio_reset_tx, io.vio_reset_all};

   for (genvar i = 0; i < 9; i++) begin : g_sync
      hssl_bit_sync #(.STAGES(SYNC_STAGES)) u_sync (
         .clk   (clk),
         .reset (reset),
         .d     (async_in[i]),
         .q     (sync_out[i])
      );
   end

   assign req_sync  = sync_out[3:0];
   assign lb_sync   = sync_out[6:4];
   assign done_sync = sync_out[8:7];
   assign req_edge  = req_sync & ~req_prev;
   assign need      = kind_done_req(kind);

   always_comb begin
      state_nxt     = state;
      kind_nxt      = kind;
      pend_clr      = '0;
      pulse_cnt_nxt = pulse_cnt;
      tmo_cnt_nxt   = tmo_cnt;
      loopback_nxt  = loopback_q;
      timeout_nxt   = timeout_q;
      seq_nxt       = seq_cnt;
      pulse_entry   = 1'b0;
      new_seq       = 1'b0;
`ifdef HSSL_VIO_CTL_AUTO_RETRY_EN
      retry_nxt     = retry_cnt;
`endif

      case (state)
         ST_IDLE: begin
            if (|pending) begin
               new_seq   = 1'b1;
               state_nxt = ST_PULSE;
               if (pending[KIND_ALL]) begin
                  kind_nxt = K_ALL;
                  pend_clr = 4'b1111;
               end else if (pending[KIND_TX]) begin
                  kind_nxt = K_TX;
                  pend_clr = 4'b0010;
               end else if (pending[KIND_RX]) begin
                  kind_nxt = K_RX;
                  pend_clr = 4'b0100;
               end else begin
                  kind_nxt = K_RX_DP;
                  pend_clr = 4'b1000;
               end
            end else if (lb_sync != loopback_q) begin
               // loopback change needs the RX datapath re-aligned
               new_seq      = 1'b1;
               state_nxt    = ST_PULSE;
               kind_nxt     = K_RX_DP;
               loopback_nxt = lb_sync;
            end
         end
         ST_PULSE: begin
            if (pulse_cnt == PULSE_W'(PULSE_CYC - 1)) begin
               state_nxt   = ST_WAIT;
               tmo_cnt_nxt = '0;
            end else begin
               pulse_cnt_nxt = pulse_cnt + 1'b1;
            end
         end
         ST_WAIT: begin
            if ((done_sync & seen_low & need) == need) begin
               state_nxt   = ST_IDLE;
               seq_nxt     = seq_cnt + 1'b1;
               timeout_nxt = 1'b0;
            end else if (tmo_cnt == TMO_W'(TIMEOUT_CYC - 1)) begin
`ifdef HSSL_VIO_CTL_AUTO_RETRY_EN
               if (retry_cnt < RETRY_W'(MAX_RETRY)) begin
                  retry_nxt   = retry_cnt + 1'b1;
                  state_nxt   = ST_PULSE;
                  pulse_entry = 1'b1;
               end else begin
                  timeout_nxt = 1'b1;
                  state_nxt   = ST_IDLE;
               end
`else
               timeout_nxt = 1'b1;
               state_nxt   = ST_IDLE;
`endif
            end else begin
               tmo_cnt_nxt = tmo_cnt + 1'b1;
            end
         end
         default: state_nxt = ST_IDLE;
      endcase

      if (new_seq) begin
         pulse_entry = 1'b1;
`ifdef HSSL_VIO_CTL_AUTO_RETRY_EN
         retry_nxt   = '0;
`endif
      end
      if (pulse_entry) pulse_cnt_nxt = '0;

      // a done that is low on the entry cycle still counts as seen
      seen_low_nxt = (pulse_entry ? 2'b00 : seen_low) | ~done_sync;
      pend_nxt     = (pending & ~pend_clr) | req_edge;
      gt_rst_nxt   = (state_nxt == ST_PULSE) ? kind_onehot(kind_nxt) : 4'b0000;
      busy_nxt     = (state_nxt != ST_IDLE);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= ST_PULSE;
         kind       <= K_ALL;
         pending    <= '0;
         req_prev   <= '0;
         pulse_cnt  <= '0;
         tmo_cnt    <= '0;
         seen_low   <= '0;
         loopback_q <= '0;
         gt_rst     <= 4'b0001;
         busy_q     <= 1'b0;
         timeout_q  <= 1'b0;
         seq_cnt    <= '0;
      end else begin
         state      <= state_nxt;
         kind       <= kind_nxt;
         pending    <= pend_nxt;
         req_prev   <= req_sync;
         pulse_cnt  <= pulse_cnt_nxt;
         tmo_cnt    <= tmo_cnt_nxt;
         seen_low   <= seen_low_nxt;
         loopback_q <= loopback_nxt;
         gt_rst     <= gt_rst_nxt;
         busy_q     <= busy_nxt;
         timeout_q  <= timeout_nxt;
         seq_cnt    <= seq_nxt;
      end
   end

`ifdef HSSL_VIO_CTL_AUTO_RETRY_EN
   always_ff @(posedge clk or posedge reset) begin
      if (reset) retry_cnt <= '0;
      else       retry_cnt <= retry_nxt;
   end
`endif

   assign io.gt_reset_all   = gt_rst[KIND_ALL];
   assign io.gt_reset_tx    = gt_rst[KIND_TX];
   assign io.gt_reset_rx    = gt_rst[KIND_RX];
   assign io.gt_reset_rx_dp = gt_rst[KIND_RX_DP];
   assign io.gt_loopback    = loopback_q;
   assign io.busy           = busy_q;
   assign io.timeout        = timeout_q;
   assign io.seq_count      = seq_cnt;
   assign io.tx_done_sync   = done_sync[0];
   assign io.rx_done_sync   = done_sync[1];

endmodule

// File: tb/tb_hssl_vio_ctl.sv
// Scoreboarded bench: expected reset pulses and sequence counts are queued at stimulus time.
module tb_hssl_vio_ctl;
   import hssl_vio_ctl_pkg::*;

   localparam int SYNC   = 2;
   localparam int PULSE  = 16;
   localparam int TMO    = 64;
   localparam int GT_DLY = 50;
`ifdef HSSL_VIO_CTL_AUTO_RETRY_EN
   localparam int TMO_PULSES = 4;
`else
   localparam int TMO_PULSES = 1;
`endif

   typedef struct {
      logic [3:0] vec;
      int         len;
   } pulse_t;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   hssl_vio_ctl_if io();

   hssl_vio_ctl #(
      .SYNC_STAGES (SYNC),
      .PULSE_CYC   (PULSE),
      .TIMEOUT_CYC (TMO)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .io    (io)
   );

   pulse_t     exp_pulse[$];
   int         exp_seq_q[$];
   int         exp_seq;
   int         n_chk;
   int         n_err;
   logic       rx_stuck;
   int         tx_cnt;
   int         rx_cnt;
   logic [3:0] gt_vec;
   logic [3:0] mon_cur;
   int         mon_len;
   bit         mon_active;
   logic [15:0] mon_prev_seq;

   assign gt_vec = {io.gt_reset_rx_dp, io.gt_reset_rx, io.gt_reset_tx, io.gt_reset_all};

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic expect_pulse(input logic [3:0] v);
      pulse_t p;
      p.vec = v;
      p.len = PULSE;
      exp_pulse.push_back(p);
   endtask

   task automatic expect_seq();
      exp_seq++;
      exp_seq_q.push_back(exp_seq & 16'hffff);
   endtask

   // mask bits: 0 all, 1 tx, 2 rx, 3 rx_dp
   task automatic trig(input logic [3:0] m);
      @(posedge clk); #1;
      io.vio_reset_all   = m[0];
      io.vio_reset_tx    = m[1];
      io.vio_reset_rx    = m[2];
      io.vio_reset_rx_dp = m[3];
      repeat (4) @(posedge clk);
      #1;
      io.vio_reset_all   = 1'b0;
      io.vio_reset_tx    = 1'b0;
      io.vio_reset_rx    = 1'b0;
      io.vio_reset_rx_dp = 1'b0;
   endtask

   task automatic wait_quiet(input int max);
      int q = 0;
      int n = 0;
      while (q < 8 && n < max) begin
         @(negedge clk);
         n++;
         if (!io.busy) q++;
         else q = 0;
      end
      if (q < 8) chk("idle_wait", q, 8);
   endtask

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_rst_all"}, io.gt_reset_all, 1'b1);
      chk({tag, "_rst_tx"}, io.gt_reset_tx, 1'b0);
      chk({tag, "_rst_rx"}, io.gt_reset_rx, 1'b0);
      chk({tag, "_rst_rx_dp"}, io.gt_reset_rx_dp, 1'b0);
      chk({tag, "_loopback"}, io.gt_loopback, 3'd0);
      chk({tag, "_busy"}, io.busy, 1'b0);
      chk({tag, "_timeout"}, io.timeout, 1'b0);
      chk({tag, "_seq"}, io.seq_count, 16'd0);
      chk({tag, "_txds"}, io.tx_done_sync, 1'b0);
      chk({tag, "_rxds"}, io.rx_done_sync, 1'b0);
   endtask

   task automatic run_stuck_rx();
      rx_stuck = 1'b1;
      for (int i = 0; i < TMO_PULSES; i++) expect_pulse(4'b0100);
      trig(4'b0100);
      wait_quiet(2000);
      chk("stuck_timeout", io.timeout, 1'b1);
      chk("stuck_seq", io.seq_count, exp_seq);
   endtask

   // GTH stand-in: done drops while its reset is high and returns GT_DLY cycles later
   initial begin
      tx_cnt = 0;
      rx_cnt = 0;
      rx_stuck = 1'b0;
      io.gt_tx_reset_done = 1'b1;
      io.gt_rx_reset_done = 1'b1;
      forever begin
         @(posedge clk); #1;
         if (io.gt_reset_all || io.gt_reset_tx) tx_cnt = GT_DLY;
         else if (tx_cnt > 0) tx_cnt--;
         if (io.gt_reset_all || io.gt_reset_rx || io.gt_reset_rx_dp) rx_cnt = GT_DLY;
         else if (rx_cnt > 0) rx_cnt--;
         io.gt_tx_reset_done = (tx_cnt == 0);
         io.gt_rx_reset_done = (rx_cnt == 0) && !rx_stuck;
      end
   end

   // output monitor: pops expected pulses and sequence counts as the DUT produces them
   initial begin
      mon_active   = 1'b0;
      mon_cur      = '0;
      mon_len      = 0;
      mon_prev_seq = '0;
      forever begin
         @(negedge clk);
         if (reset) begin
            mon_active   = (gt_vec != 4'b0000);
            mon_cur      = gt_vec;
            mon_len      = 0;
            mon_prev_seq = io.seq_count;
         end else begin
            if (gt_vec != 4'b0000) begin
               if (!mon_active) begin
                  mon_active = 1'b1;
                  mon_cur    = gt_vec;
                  mon_len    = 1;
               end else begin
                  mon_len++;
               end
            end else if (mon_active) begin
               pulse_t p;
               mon_active = 1'b0;
               if (exp_pulse.size() == 0) begin
                  chk("pulse_unexpected", mon_cur, 4'b0000);
               end else begin
                  p = exp_pulse.pop_front();
                  chk("pulse_kind", mon_cur, p.vec);
                  chk("pulse_len", mon_len, p.len);
               end
            end
            if (io.seq_count != mon_prev_seq) begin
               if (exp_seq_q.size() == 0) begin
                  chk("seq_unexpected", io.seq_count, mon_prev_seq);
               end else begin
                  int es;
                  es = exp_seq_q.pop_front();
                  chk("seq_step", io.seq_count, es);
               end
               mon_prev_seq = io.seq_count;
            end
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog expired n_chk=%0d", n_chk);
      $fatal(1);
   end

   initial begin
      int  lat;
      int  n;
      bit  saw;
      n_chk   = 0;
      n_err   = 0;
      exp_seq = 0;
      reset   = 1'b1;
      io.vio_reset_all   = 1'b0;
      io.vio_reset_tx    = 1'b0;
      io.vio_reset_rx    = 1'b0;
      io.vio_reset_rx_dp = 1'b0;
      io.vio_loopback    = 3'd0;

      // 1: reset values, power-up ALL sequence
      @(posedge clk); #1;
      check_reset_outputs("t1");
      expect_pulse(4'b0001);
      expect_seq();
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
      wait_quiet(400);
      chk("t1_seq", io.seq_count, 16'd1);
      chk("t1_timeout", io.timeout, 1'b0);
      chk("t1_txds", io.tx_done_sync, 1'b1);

      // 2: single TX request latency
      expect_pulse(4'b0010);
      expect_seq();
      @(posedge clk); #1;
      io.vio_reset_tx = 1'b1;
      lat = 0;
      while (!io.gt_reset_tx && lat < 20) begin
         @(posedge clk); #1;
         lat++;
      end
      chk("t2_latency", lat, SYNC + 2);
      repeat (4) @(posedge clk);
      #1 io.vio_reset_tx = 1'b0;
      wait_quiet(400);
      chk("t2_seq", io.seq_count, exp_seq);

      // 3: TX and RX in the same cycle -> TX first
      expect_pulse(4'b0010);
      expect_pulse(4'b0100);
      expect_seq();
      expect_seq();
      trig(4'b0110);
      wait_quiet(800);
      chk("t3_seq", io.seq_count, exp_seq);

      // repeat TX edges while busy merge into one request
      expect_pulse(4'b0100);
      expect_pulse(4'b0010);
      expect_seq();
      expect_seq();
      trig(4'b0100);
      repeat (6) @(posedge clk);
      trig(4'b0010);
      trig(4'b0010);
      wait_quiet(800);
      chk("merge_seq", io.seq_count, exp_seq);

      // ALL supersedes a simultaneous TX
      expect_pulse(4'b0001);
      expect_seq();
      trig(4'b0011);
      wait_quiet(800);
      chk("all_clr_seq", io.seq_count, exp_seq);

      // 4: loopback change -> RX_DP sequence
      expect_pulse(4'b1000);
      expect_seq();
      @(posedge clk); #1;
      io.vio_loopback = 3'd2;
      wait_quiet(400);
      chk("t4_loopback", io.gt_loopback, 3'd2);
      chk("t4_seq", io.seq_count, exp_seq);

      // 5: RX done never returns
      run_stuck_rx();

      // 6: reset during WAIT of a TX sequence
      expect_pulse(4'b0010);
      trig(4'b0010);
      n   = 0;
      saw = 1'b0;
      while (!io.gt_reset_tx && n < 100) begin
         @(negedge clk);
         n++;
      end
      while (io.gt_reset_tx && n < 200) begin
         saw = 1'b1;
         @(negedge clk);
         n++;
      end
      chk("t6_tx_pulse_seen", saw, 1'b1);
      repeat (10) @(posedge clk);
      rx_stuck = 1'b0;
      #1 reset = 1'b1;
      #1;
      check_reset_outputs("t6");
      exp_seq = 0;
      // power-up ALL, then the still-requested loopback 2 reapplies via RX_DP
      expect_pulse(4'b0001);
      expect_pulse(4'b1000);
      expect_seq();
      expect_seq();
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;
      wait_quiet(600);
      chk("t6_seq", io.seq_count, 16'd2);
      chk("t6_loopback", io.gt_loopback, 3'd2);

      // timeout is sticky until a sequence completes
      run_stuck_rx();
      rx_stuck = 1'b0;
      repeat (5) @(posedge clk);
      expect_pulse(4'b0100);
      expect_seq();
      trig(4'b0100);
      wait_quiet(400);
      chk("recover_timeout", io.timeout, 1'b0);
      chk("recover_seq", io.seq_count, exp_seq);

      repeat (5) @(posedge clk);
      chk("pulse_queue_empty", exp_pulse.size(), 0);
      chk("seq_queue_empty", exp_seq_q.size(), 0);

      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end

endmodule
